// File: rtl/rs_bank_pkg.sv
// Shared definitions for the reservation-station bank: FU classes, default sizing, tag type.
package rs_bank_pkg;

  localparam int unsigned DEF_RS_DEPTH = 8;
  localparam int unsigned DEF_NUM_FU   = 5;
  localparam int unsigned DEF_CDB_N    = 2;
  localparam int unsigned DEF_TAG_W    = 6;
  localparam int unsigned OPC_W        = 7;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_LD  = 3'd1,
    FU_ST  = 3'd2,
    FU_FP1 = 3'd3,
    FU_FP2 = 3'd4
  } fu_type_e;

  typedef logic [DEF_TAG_W-1:0] tag_t;

endpackage

// File: rtl/rs_bank_select.sv
// Lowest-index priority picker: request vector in, any-valid and one-hot grant out.
module rs_select
  import rs_bank_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid_c,
  output logic [N-1:0] o_onehot_c
);

  // x & -x isolates the lowest set bit
  always_comb begin
    o_valid_c  = |i_req;
    o_onehot_c = i_req & (~i_req + N'(1));
  end

endmodule

// File: rtl/rs_bank.sv
// Shared reservation station: holds dispatched ops until both sources are ready,
// wakes them from CDB broadcasts and issues one ready op per FU class per cycle.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int unsigned RS_DEPTH = DEF_RS_DEPTH,
  parameter int unsigned NUM_FU   = DEF_NUM_FU,
  parameter int unsigned CDB_N    = DEF_CDB_N,
  parameter int unsigned TAG_W    = DEF_TAG_W
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [$clog2(NUM_FU)-1:0]      disp_fu,
  input  logic [OPC_W-1:0]               disp_opcode,
  input  logic [TAG_W-1:0]               disp_T,
  input  logic [TAG_W-1:0]               disp_T1,
  input  logic [TAG_W-1:0]               disp_T2,
  input  logic                           disp_T1_rdy,
  input  logic                           disp_T2_rdy,
  input  logic [CDB_N-1:0]               cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]         cdb_tag,
  input  logic                           squash,
  output logic [NUM_FU-1:0]              iss_valid,
  input  logic [NUM_FU-1:0]              iss_ready,
  output logic [NUM_FU*OPC_W-1:0]        iss_opcode,
  output logic [NUM_FU*TAG_W-1:0]        iss_T,
  output logic [NUM_FU*TAG_W-1:0]        iss_T1,
  output logic [NUM_FU*TAG_W-1:0]        iss_T2,
  output logic [$clog2(RS_DEPTH+1)-1:0]  free_count
);

  localparam int unsigned FU_W  = $clog2(NUM_FU);
  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic             busy;
    logic [FU_W-1:0]  fu;
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] t;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic             rdy1;
    logic             rdy2;
  } entry_t;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                   input logic [CDB_N-1:0]       vld,
                                   input logic [CDB_N*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(CDB_N); k++) begin
      hit = hit | (vld[k] && (tags[k*TAG_W +: TAG_W] == tag));
    end
    return hit;
  endfunction

  entry_t              r_entry [RS_DEPTH];
  entry_t              w_new_entry;
  logic [RS_DEPTH-1:0] w_free;
  logic                w_alloc_valid;
  logic [RS_DEPTH-1:0] w_alloc_oh;
  logic                w_disp_fire;
  logic [RS_DEPTH-1:0] w_iss_req [NUM_FU];
  logic [RS_DEPTH-1:0] w_iss_oh  [NUM_FU];
  logic [NUM_FU-1:0]   w_cand;
  logic [NUM_FU-1:0]   w_fire;
  logic [RS_DEPTH-1:0] w_clear;
  logic [CNT_W-1:0]    w_busy_cnt;

  // Per-entry request vectors for allocation and per-class issue selection
  always_comb begin
    w_free = '0;
    for (int f = 0; f < int'(NUM_FU); f++) begin
      w_iss_req[f] = '0;
    end
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      w_free[i] = ~r_entry[i].busy;
      for (int f = 0; f < int'(NUM_FU); f++) begin
        w_iss_req[f][i] = r_entry[i].busy && (r_entry[i].fu == FU_W'(f)) &&
                          r_entry[i].rdy1 && r_entry[i].rdy2;
      end
    end
  end

  rs_select #(.N(RS_DEPTH)) u_alloc (
    .i_req      (w_free),
    .o_valid_c  (w_alloc_valid),
    .o_onehot_c (w_alloc_oh)
  );

  for (genvar f = 0; f < int'(NUM_FU); f++) begin : g_iss
    rs_select #(.N(RS_DEPTH)) u_iss (
      .i_req      (w_iss_req[f]),
      .o_valid_c  (w_cand[f]),
      .o_onehot_c (w_iss_oh[f])
    );
  end

  // Acceptance depends only on registered busy bits, so a slot freed this cycle waits a cycle
  assign disp_ready  = w_alloc_valid;
  assign w_disp_fire = disp_valid && w_alloc_valid && !squash;
  assign iss_valid   = w_cand & {NUM_FU{~squash}};
  assign w_fire      = iss_valid & iss_ready;

  always_comb begin
    w_new_entry        = '0;
    w_new_entry.busy   = 1'b1;
    w_new_entry.fu     = disp_fu;
    w_new_entry.opcode = disp_opcode;
    w_new_entry.t      = disp_T;
    w_new_entry.t1     = disp_T1;
    w_new_entry.t2     = disp_T2;
    w_new_entry.rdy1   = disp_T1_rdy || (disp_T1 == '0) || cdb_hit(disp_T1, cdb_valid, cdb_tag);
    w_new_entry.rdy2   = disp_T2_rdy || (disp_T2 == '0) || cdb_hit(disp_T2, cdb_valid, cdb_tag);
  end

  // Issue payload mux and per-entry release on handshake
  always_comb begin
    iss_opcode = '0;
    iss_T      = '0;
    iss_T1     = '0;
    iss_T2     = '0;
    w_clear    = '0;
    for (int f = 0; f < int'(NUM_FU); f++) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        if (iss_valid[f] && w_iss_oh[f][i]) begin
          iss_opcode[f*OPC_W +: OPC_W] = r_entry[i].opcode;
          iss_T[f*TAG_W +: TAG_W]      = r_entry[i].t;
          iss_T1[f*TAG_W +: TAG_W]     = r_entry[i].t1;
          iss_T2[f*TAG_W +: TAG_W]     = r_entry[i].t2;
        end
        if (w_fire[f] && w_iss_oh[f][i]) begin
          w_clear[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      w_busy_cnt = w_busy_cnt + CNT_W'(r_entry[i].busy);
    end
  end

  assign free_count = CNT_W'(RS_DEPTH) - w_busy_cnt;

  // Entry state: squash beats everything, else write on dispatch, else wakeup/release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        if (squash) begin
          r_entry[i].busy <= 1'b0;
        end else if (w_disp_fire && w_alloc_oh[i]) begin
          r_entry[i] <= w_new_entry;
        end else if (r_entry[i].busy) begin
          if (w_clear[i]) begin
            r_entry[i].busy <= 1'b0;
          end
          if (cdb_hit(r_entry[i].t1, cdb_valid, cdb_tag)) begin
            r_entry[i].rdy1 <= 1'b1;
          end
          if (cdb_hit(r_entry[i].t2, cdb_valid, cdb_tag)) begin
            r_entry[i].rdy2 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: issue scoreboard checked by a negedge monitor plus inline state checks.
module tb_rs_bank;
  import rs_bank_pkg::*;

  localparam int NF = 5;
  localparam int TW = 6;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            disp_valid, disp_ready;
  logic [2:0]      disp_fu;
  logic [6:0]      disp_opcode;
  logic [TW-1:0]   disp_T, disp_T1, disp_T2;
  logic            disp_T1_rdy, disp_T2_rdy;
  logic [1:0]      cdb_valid;
  logic [2*TW-1:0] cdb_tag;
  logic            squash;
  logic [NF-1:0]   iss_valid, iss_ready;
  logic [NF*7-1:0] iss_opcode;
  logic [NF*TW-1:0] iss_T, iss_T1, iss_T2;
  logic [3:0]      free_count;

  typedef struct {
    int         fu;
    logic [6:0] opc;
    logic [5:0] t;
    logic [5:0] t1;
    logic [5:0] t2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  rs_bank dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_fu     (disp_fu),
    .disp_opcode (disp_opcode),
    .disp_T      (disp_T),
    .disp_T1     (disp_T1),
    .disp_T2     (disp_T2),
    .disp_T1_rdy (disp_T1_rdy),
    .disp_T2_rdy (disp_T2_rdy),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .squash      (squash),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_opcode  (iss_opcode),
    .iss_T       (iss_T),
    .iss_T1      (iss_T1),
    .iss_T2      (iss_T2),
    .free_count  (free_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] slot_t(input int f);
    return iss_T[f*TW +: TW];
  endfunction

  function automatic logic [6:0] slot_opc(input int f);
    return iss_opcode[f*7 +: 7];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input int fu, input logic [6:0] opc, input logic [5:0] t,
                          input logic [5:0] t1, input logic [5:0] t2,
                          input logic r1, input logic r2, input bit push);
    exp_t e;
    disp_valid  = 1'b1;
    disp_fu     = 3'(fu);
    disp_opcode = opc;
    disp_T      = t;
    disp_T1     = t1;
    disp_T2     = t2;
    disp_T1_rdy = r1;
    disp_T2_rdy = r2;
    if (push) begin
      e.fu = fu; e.opc = opc; e.t = t; e.t1 = t1; e.t2 = t2;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_disp(input int fu, input logic [6:0] opc, input logic [5:0] t,
                         input logic [5:0] t1, input logic [5:0] t2,
                         input logic r1, input logic r2, input bit push);
    set_disp(fu, opc, t, t1, t2, r1, r2, push);
    cyc();
    disp_valid = 1'b0;
  endtask

  // Scoreboard monitor: every accepted issue must match the oldest expected op of its class
  always @(negedge clock) begin
    if (reset_n) begin
      for (int f = 0; f < NF; f++) begin
        if (iss_valid[f] && iss_ready[f]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].fu == f) idx = j;
          end
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL issue_unexpected fu=%0d: got T=%0d expected no issue", f, iss_T[f*TW +: TW]);
          end else begin
            if ({iss_opcode[f*7 +: 7], iss_T[f*TW +: TW], iss_T1[f*TW +: TW], iss_T2[f*TW +: TW]} !==
                {exp_q[idx].opc, exp_q[idx].t, exp_q[idx].t1, exp_q[idx].t2}) begin
              failures++;
              $display("FAIL issue_payload fu=%0d: got opc=%0h T=%0d T1=%0d T2=%0d expected opc=%0h T=%0d T1=%0d T2=%0d",
                       f, iss_opcode[f*7 +: 7], iss_T[f*TW +: TW], iss_T1[f*TW +: TW], iss_T2[f*TW +: TW],
                       exp_q[idx].opc, exp_q[idx].t, exp_q[idx].t1, exp_q[idx].t2);
            end
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    disp_valid = 1'b0; disp_fu = '0; disp_opcode = '0;
    disp_T = '0; disp_T1 = '0; disp_T2 = '0; disp_T1_rdy = 1'b0; disp_T2_rdy = 1'b0;
    cdb_valid = '0; cdb_tag = '0; squash = 1'b0; iss_ready = '1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("reset_free", free_count, 8);
    chk("reset_disp_ready", disp_ready, 1);
    chk("reset_iss_valid", iss_valid, 0);

    // 1: ready ALU op issues the cycle after dispatch
    do_disp(int'(FU_ALU), 7'h33, 6'd5, 6'd3, 6'd4, 1'b1, 1'b1, 1'b1);
    chk("t1_iss_valid", iss_valid, 5'b00001);
    chk("t1_iss_T", slot_t(0), 5);
    chk("t1_free_7", free_count, 7);
    cyc();
    chk("t1_free_8", free_count, 8);
    chk("t1_iss_idle", iss_valid, 0);

    // 2: wakeup via CDB slot 0, no same-cycle bypass; T2 is the zero register
    do_disp(int'(FU_ALU), 7'h13, 6'd10, 6'd7, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("t2_wait0", iss_valid[0], 0);
    cyc();
    chk("t2_wait1", iss_valid[0], 0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd7};
    #1;
    chk("t2_no_bypass", iss_valid[0], 0);
    cyc();
    cdb_valid = '0;
    chk("t2_woken", iss_valid[0], 1);
    chk("t2_iss_T", slot_t(0), 10);
    cyc();
    chk("t2_free_8", free_count, 8);

    // 3: source woken by CDB slot 1 in the dispatch cycle
    set_disp(int'(FU_LD), 7'h03, 6'd11, 6'd2, 6'd9, 1'b1, 1'b0, 1'b1);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    cyc();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    chk("t3_iss_valid_ld", iss_valid, 5'b00010);
    chk("t3_iss_T2", iss_T2[1*TW +: TW], 9);
    cyc();
    chk("t3_free_8", free_count, 8);

    // Simultaneous dispatch and issue leave free_count unchanged
    iss_ready = '0;
    do_disp(int'(FU_ALU), 7'h33, 6'd40, 6'd1, 6'd2, 1'b1, 1'b1, 1'b1);
    chk("sim_free_7", free_count, 7);
    iss_ready = 5'b00001;
    set_disp(int'(FU_ALU), 7'h33, 6'd41, 6'd1, 6'd2, 1'b1, 1'b1, 1'b1);
    cyc();
    disp_valid = 1'b0;
    chk("sim_free_net0", free_count, 7);
    chk("sim_next_T", slot_t(0), 41);
    cyc();
    chk("sim_free_8", free_count, 8);

    // 4: fill, ignored dispatch when full, freed slot not reusable same cycle
    iss_ready = '0;
    for (int i = 0; i < 8; i++) begin
      do_disp(int'(FU_ALU), 7'(i + 1), 6'(32 + i), 6'd1, 6'd2, 1'b1, 1'b1, 1'b1);
    end
    chk("t4_free_0", free_count, 0);
    chk("t4_disp_ready_0", disp_ready, 0);
    set_disp(int'(FU_ALU), 7'h7f, 6'd60, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t4_ignored_free", free_count, 0);
    chk("t4_head_T", slot_t(0), 32);
    set_disp(int'(FU_ALU), 7'h7e, 6'd61, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
    iss_ready = 5'b00001;
    #1;
    chk("t4_ready_still_0", disp_ready, 0);
    cyc();
    iss_ready  = '0;
    disp_valid = 1'b0;
    chk("t4_disp_ready_1", disp_ready, 1);
    chk("t4_free_1", free_count, 1);
    iss_ready = '1;
    repeat (7) cyc();
    chk("t4_drained", free_count, 8);

    // 5: two ready FP1 ops in entries 2 and 5, stalled FU keeps payload stable
    iss_ready = '0;
    do_disp(int'(FU_ALU), 7'h33, 6'd20, 6'd50, 6'd0, 1'b0, 1'b0, 1'b0);
    do_disp(int'(FU_ALU), 7'h33, 6'd21, 6'd50, 6'd0, 1'b0, 1'b0, 1'b0);
    do_disp(int'(FU_FP1), 7'h53, 6'd22, 6'd12, 6'd13, 1'b1, 1'b1, 1'b1);
    do_disp(int'(FU_LD),  7'h03, 6'd23, 6'd51, 6'd0, 1'b0, 1'b0, 1'b0);
    do_disp(int'(FU_LD),  7'h03, 6'd24, 6'd51, 6'd0, 1'b0, 1'b0, 1'b0);
    do_disp(int'(FU_FP1), 7'h57, 6'd25, 6'd14, 6'd15, 1'b1, 1'b1, 1'b1);
    chk("t5_only_fp1", iss_valid, 5'b01000);
    chk("t5_first_T", slot_t(3), 22);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t5_stable", {iss_valid[3], slot_opc(3), slot_t(3)}, {1'b1, 7'h53, 6'd22});
    end
    iss_ready = 5'b01000;
    cyc();
    chk("t5_second_T", slot_t(3), 25);
    cyc();
    chk("t5_fp1_empty", iss_valid[3], 0);
    iss_ready = '0;
    chk("t5_free_4", free_count, 4);

    // 6: squash with dispatch and ready issue candidates in the same cycle
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd51};
    cyc();
    cdb_valid = '0;
    chk("t6_ld_ready", iss_valid, 5'b00010);
    squash = 1'b1;
    set_disp(int'(FU_FP2), 7'h77, 6'd30, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
    iss_ready = '1;
    #1;
    chk("t6_squash_gates_issue", iss_valid, 0);
    cyc();
    squash     = 1'b0;
    disp_valid = 1'b0;
    chk("t6_free_8", free_count, 8);
    chk("t6_no_issue", iss_valid, 0);
    cyc();
    chk("t6_no_write", iss_valid, 0);
    chk("t6_free_still_8", free_count, 8);

    // Asynchronous reset mid-operation
    iss_ready = '0;
    do_disp(int'(FU_ST), 7'h23, 6'd33, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
    chk("ar_free_7", free_count, 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_free_8", free_count, 8);
    chk("ar_iss_valid", iss_valid, 0);
    chk("ar_disp_ready", disp_ready, 1);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ar_after_release", iss_valid, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
